// File: rtl/airlock_pkg.sv
// airlock_pkg: shared types and default timing for the airlock sequencer.
// Holds the FSM state enum, side encoding and default dwell/timeout values.
package airlock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EQ_SRC,
    ST_OPEN_SRC,
    ST_CYCLE_DST,
    ST_OPEN_DST,
    ST_FAULT
  } state_t;

  typedef enum logic {
    SIDE_IN  = 1'b0,
    SIDE_OUT = 1'b1
  } side_t;

  localparam int DOOR_CYCLES_DEF  = 8;
  localparam int PUMP_TIMEOUT_DEF = 64;
  localparam int CNT_W_DEF        = 8;

  function automatic side_t opp(input side_t s);
    return (s == SIDE_IN) ? SIDE_OUT : SIDE_IN;
  endfunction

endpackage

// File: rtl/airlock_sequencer_if.sv
// airlock_sequencer_if: requests, chamber status, chamber controls, doors.
// master = sequencer (drives ctrl/doors/done/busy/fault); slave = chamber side.
interface airlock_sequencer_if;

  logic req_in;
  logic req_out;
  logic pressurized;
  logic evacuated;
  logic pressurize_ctrl;
  logic evacuate_ctrl;
  logic inner_open;
  logic outer_open;
  logic done_in;
  logic done_out;
  logic busy;
  logic fault;

  modport master (
    input  req_in, req_out,
    input  pressurized, evacuated,
    output pressurize_ctrl, evacuate_ctrl,
    output inner_open, outer_open,
    output done_in, done_out,
    output busy, fault
  );

  modport slave (
    output req_in, req_out,
    output pressurized, evacuated,
    input  pressurize_ctrl, evacuate_ctrl,
    input  inner_open, outer_open,
    input  done_in, done_out,
    input  busy, fault
  );

endinterface

// File: rtl/airlock_timer.sv
// airlock_timer: loadable down-counter shared by door dwell and pump timeout.
// Ports: clk, rst, load_i, load_val_i[CNT_W], expired_o (count is zero).
module airlock_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/airlock_sequencer.sv
// airlock_sequencer: arbitrates inner/outer passages and interlocks the doors.
// Ports: clk, rst (async, high), al (master: req/status in, ctrl/door/done out).
module airlock_sequencer
  import airlock_pkg::*;
#(
  parameter int DOOR_CYCLES  = DOOR_CYCLES_DEF,
  parameter int PUMP_TIMEOUT = PUMP_TIMEOUT_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  airlock_sequencer_if.master al
);

  localparam logic [CNT_W-1:0] DOOR_LD = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [CNT_W-1:0] PUMP_LD = CNT_W'(PUMP_TIMEOUT - 1);

  state_t state_q, state_d;
  side_t  side_q, side_d;
  side_t  last_q, last_d;
  side_t  gnt;
  logic   pin_q, pin_d;
  logic   pout_q, pout_d;
  logic   press_q, press_d;
  logic   evac_q, evac_d;
  logic   inner_q, inner_d;
  logic   outer_q, outer_d;
  logic   din_q, din_d;
  logic   dout_q, dout_d;
  logic   busy_q, busy_d;
  logic   fault_q, fault_d;

  logic   eff_in, eff_out;
  logic   gnt_ok, src_ok, dst_ok;
  logic   tmr_load, tmr_exp;
  logic [CNT_W-1:0] tmr_val;

  assign eff_in  = pin_q | al.req_in;
  assign eff_out = pout_q | al.req_out;

  // Status that matches a side: pressurized for inner, evacuated for outer.
  assign gnt_ok = (gnt == SIDE_IN) ? al.pressurized : al.evacuated;
  assign src_ok = (side_q == SIDE_IN) ? al.pressurized : al.evacuated;
  assign dst_ok = (side_q == SIDE_IN) ? al.evacuated : al.pressurized;

  always_comb begin
    if (eff_in && !eff_out) begin
      gnt = SIDE_IN;
    end else if (eff_out && !eff_in) begin
      gnt = SIDE_OUT;
    end else if (al.pressurized) begin
      gnt = SIDE_IN;
    end else if (al.evacuated) begin
      gnt = SIDE_OUT;
    end else begin
      gnt = opp(last_q);
    end
  end

  always_comb begin
    state_d = state_q;
    side_d  = side_q;
    last_d  = last_q;
    pin_d   = eff_in;
    pout_d  = eff_out;
    din_d   = 1'b0;
    dout_d  = 1'b0;
    press_d = 1'b0;
    evac_d  = 1'b0;
    inner_d = 1'b0;
    outer_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (eff_in || eff_out) begin
          side_d  = gnt;
          last_d  = gnt;
          state_d = gnt_ok ? ST_OPEN_SRC : ST_EQ_SRC;
        end
      end
      ST_EQ_SRC: begin
        if (src_ok) begin
          state_d = ST_OPEN_SRC;
        end else if (tmr_exp) begin
          state_d = ST_FAULT;
        end
      end
      ST_OPEN_SRC: begin
        if (!src_ok) begin
          state_d = ST_FAULT;
        end else if (tmr_exp) begin
          state_d = ST_CYCLE_DST;
        end
      end
      ST_CYCLE_DST: begin
        if (dst_ok) begin
          state_d = ST_OPEN_DST;
        end else if (tmr_exp) begin
          state_d = ST_FAULT;
        end
      end
      ST_OPEN_DST: begin
        if (!dst_ok) begin
          state_d = ST_FAULT;
        end else if (tmr_exp) begin
          state_d = ST_IDLE;
          // A request sampled on this very edge is a new one and survives.
          if (side_q == SIDE_IN) begin
            din_d = 1'b1;
            pin_d = al.req_in;
          end else begin
            dout_d = 1'b1;
            pout_d = al.req_out;
          end
        end
      end
      ST_FAULT: begin
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase

    // Outputs are decoded from the next state so they register on entry.
    unique case (state_d)
      ST_EQ_SRC: begin
        if (side_d == SIDE_IN) press_d = 1'b1;
        else                   evac_d  = 1'b1;
      end
      ST_OPEN_SRC: begin
        if (side_d == SIDE_IN) inner_d = 1'b1;
        else                   outer_d = 1'b1;
      end
      ST_CYCLE_DST: begin
        if (side_d == SIDE_IN) evac_d  = 1'b1;
        else                   press_d = 1'b1;
      end
      ST_OPEN_DST: begin
        if (side_d == SIDE_IN) outer_d = 1'b1;
        else                   inner_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign busy_d  = (state_d != ST_IDLE);
  assign fault_d = (state_d == ST_FAULT);

  // Timer restarts on every state change; door states dwell, pump states time out.
  assign tmr_load = (state_d != state_q);
  assign tmr_val  = (state_d == ST_OPEN_SRC || state_d == ST_OPEN_DST)
                    ? DOOR_LD : PUMP_LD;

  airlock_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .expired_o (tmr_exp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      side_q  <= SIDE_IN;
      last_q  <= SIDE_IN;
      pin_q   <= 1'b0;
      pout_q  <= 1'b0;
      press_q <= 1'b0;
      evac_q  <= 1'b0;
      inner_q <= 1'b0;
      outer_q <= 1'b0;
      din_q   <= 1'b0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      side_q  <= side_d;
      last_q  <= last_d;
      pin_q   <= pin_d;
      pout_q  <= pout_d;
      press_q <= press_d;
      evac_q  <= evac_d;
      inner_q <= inner_d;
      outer_q <= outer_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
    end
  end

  assign al.pressurize_ctrl = press_q;
  assign al.evacuate_ctrl   = evac_q;
  assign al.inner_open      = inner_q;
  assign al.outer_open      = outer_q;
  assign al.done_in         = din_q;
  assign al.done_out        = dout_q;
  assign al.busy            = busy_q;
  assign al.fault           = fault_q;

endmodule

// File: tb/tb_airlock_sequencer.sv
// tb_airlock_sequencer: directed passages against a mock chamber.
// Mock reaches target status DLY cycles after its ctrl rises, or never if stuck.
module tb_airlock_sequencer;
  import airlock_pkg::*;

  localparam int DLY = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  airlock_sequencer_if bus();

  airlock_sequencer #(
    .DOOR_CYCLES (DOOR_CYCLES_DEF),
    .PUMP_TIMEOUT(PUMP_TIMEOUT_DEF),
    .CNT_W       (CNT_W_DEF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .al (bus)
  );

  // cnt: 0 outer, 1 inner, 2 press, 3 evac, 4 done_in, 5 done_out
  int cnt[6] = '{default: 0};
  int cyc = 0;
  int t_din = 0;
  int t_dout = 0;
  int n_viol = 0;
  int pc = 0;
  int ec = 0;
  bit init_press = 1'b0;
  bit stuck = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  always @(negedge clk) begin
    cyc++;
    if (bus.outer_open) cnt[0]++;
    if (bus.inner_open) cnt[1]++;
    if (bus.pressurize_ctrl) cnt[2]++;
    if (bus.evacuate_ctrl) cnt[3]++;
    if (bus.done_in) begin cnt[4]++; t_din = cyc; end
    if (bus.done_out) begin cnt[5]++; t_dout = cyc; end
    if (bus.inner_open && bus.outer_open) n_viol++;
    if (bus.pressurize_ctrl && bus.evacuate_ctrl) n_viol++;
    if ((bus.pressurize_ctrl || bus.evacuate_ctrl) &&
        (bus.inner_open || bus.outer_open)) n_viol++;
    if (bus.inner_open && !bus.pressurized) n_viol++;
    if (bus.outer_open && !bus.evacuated) n_viol++;
    if (rst) begin
      bus.pressurized = init_press;
      bus.evacuated   = !init_press;
      pc = 0;
      ec = 0;
    end else begin
      if (bus.pressurize_ctrl && !stuck) begin
        bus.evacuated = 1'b0;
        pc++;
        if (pc >= DLY) bus.pressurized = 1'b1;
      end else begin
        pc = 0;
      end
      if (bus.evacuate_ctrl && !stuck) begin
        bus.pressurized = 1'b0;
        ec++;
        if (ec >= DLY) bus.evacuated = 1'b1;
      end else begin
        ec = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse(input logic i, input logic o);
    @(negedge clk);
    bus.req_in  = i;
    bus.req_out = o;
    @(negedge clk);
    bus.req_in  = 1'b0;
    bus.req_out = 1'b0;
    #1;
  endtask

  task automatic do_reset(input bit press);
    init_press = press;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  function automatic logic [7:0] outs();
    return {bus.pressurize_ctrl, bus.evacuate_ctrl, bus.inner_open,
            bus.outer_open, bus.done_in, bus.done_out, bus.busy, bus.fault};
  endfunction

  int s[6];
  int c0;
  int d;

  initial begin
    bus.req_in  = 1'b0;
    bus.req_out = 1'b0;

    // Reset, then outer passage with chamber already evacuated.
    do_reset(1'b0);
    chk("reset_outs", {24'd0, outs()}, 32'd0);
    s = cnt;
    pulse(1'b0, 1'b1);
    c0 = cyc;
    chk("t1_outer_now", bus.outer_open, 1);
    chk("t1_busy", bus.busy, 1);
    repeat (40) @(negedge clk);
    #1;
    chk("t1_outer", cnt[0] - s[0], 8);
    chk("t1_press", cnt[2] - s[2], 6);
    chk("t1_inner", cnt[1] - s[1], 8);
    chk("t1_evac", cnt[3] - s[3], 0);
    chk("t1_dout", cnt[5] - s[5], 1);
    chk("t1_din", cnt[4] - s[4], 0);
    chk("t1_dout_time", t_dout - c0, 22);
    chk("t1_idle", bus.busy, 0);

    // Chamber now pressurized: outer request must equalize first.
    s = cnt;
    pulse(1'b0, 1'b1);
    c0 = cyc;
    chk("t2_evac_now", bus.evacuate_ctrl, 1);
    chk("t2_outer_now", bus.outer_open, 0);
    repeat (50) @(negedge clk);
    #1;
    chk("t2_evac", cnt[3] - s[3], 6);
    chk("t2_outer", cnt[0] - s[0], 8);
    chk("t2_press", cnt[2] - s[2], 6);
    chk("t2_inner", cnt[1] - s[1], 8);
    chk("t2_dout", cnt[5] - s[5], 1);
    chk("t2_dout_time", t_dout - c0, 28);

    // Simultaneous requests, chamber evacuated: outer first, then inner.
    do_reset(1'b0);
    s = cnt;
    pulse(1'b1, 1'b1);
    chk("t3_outer_first", bus.outer_open, 1);
    chk("t3_inner_first", bus.inner_open, 0);
    repeat (70) @(negedge clk);
    #1;
    chk("t3_dout", cnt[5] - s[5], 1);
    chk("t3_din", cnt[4] - s[4], 1);
    d = t_din - t_dout;
    chk("t3_gap", d, 23);
    chk("t3_outer", cnt[0] - s[0], 16);
    chk("t3_inner", cnt[1] - s[1], 16);
    chk("t3_evac", cnt[3] - s[3], 6);
    chk("t3_idle", bus.busy, 0);

    // Three inner pulses during an outer passage collapse into one.
    s = cnt;
    pulse(1'b0, 1'b1);
    chk("t4_outer_now", bus.outer_open, 1);
    repeat (2) @(negedge clk);
    pulse(1'b1, 1'b0);
    repeat (5) @(negedge clk);
    pulse(1'b1, 1'b0);
    repeat (5) @(negedge clk);
    pulse(1'b1, 1'b0);
    repeat (80) @(negedge clk);
    #1;
    chk("t4_dout", cnt[5] - s[5], 1);
    chk("t4_din", cnt[4] - s[4], 1);
    chk("t4_inner", cnt[1] - s[1], 16);
    chk("t4_idle", bus.busy, 0);

    // Chamber never pressurizes: timeout to sticky fault.
    stuck = 1'b1;
    s = cnt;
    pulse(1'b0, 1'b1);
    repeat (80) @(negedge clk);
    #1;
    chk("t5_press", cnt[2] - s[2], 64);
    chk("t5_outer", cnt[0] - s[0], 8);
    chk("t5_fault", bus.fault, 1);
    chk("t5_quiet", {28'd0, bus.pressurize_ctrl, bus.evacuate_ctrl,
                     bus.inner_open, bus.outer_open}, 0);
    pulse(1'b1, 1'b0);
    repeat (20) @(negedge clk);
    #1;
    chk("t5_fault_held", bus.fault, 1);
    chk("t5_no_inner", cnt[1] - s[1], 0);
    chk("t5_no_done", cnt[4] - s[4], 0);

    // Asynchronous reset during OPEN_SRC also drops pending requests.
    stuck = 1'b0;
    do_reset(1'b0);
    chk("t6_fault_clr", {24'd0, outs()}, 32'd0);
    pulse(1'b0, 1'b1);
    repeat (2) @(negedge clk);
    pulse(1'b1, 1'b0);
    chk("t6_outer_pre", bus.outer_open, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_outer_async", bus.outer_open, 0);
    chk("t6_busy_async", bus.busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    s = cnt;
    repeat (40) @(negedge clk);
    #1;
    chk("t6_no_outer", cnt[0] - s[0], 0);
    chk("t6_no_inner", cnt[1] - s[1], 0);
    chk("t6_idle", bus.busy, 0);

    chk("interlock", n_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
